// File: rtl/ex_mem_stage_pkg.sv
// Shared types and constants for the EX->MEM pipeline stage.
package ex_mem_stage_pkg;

    localparam int XLEN     = 32;
    localparam int REG_W    = 5;
    localparam int FUNCT3_W = 3;

    // funct3 access size/sign codes forwarded to the memory stage
    localparam logic [FUNCT3_W-1:0] F3_LB  = 3'b000;
    localparam logic [FUNCT3_W-1:0] F3_LH  = 3'b001;
    localparam logic [FUNCT3_W-1:0] F3_LW  = 3'b010;
    localparam logic [FUNCT3_W-1:0] F3_LBU = 3'b100;
    localparam logic [FUNCT3_W-1:0] F3_LHU = 3'b101;
    localparam logic [FUNCT3_W-1:0] F3_SB  = 3'b000;
    localparam logic [FUNCT3_W-1:0] F3_SH  = 3'b001;
    localparam logic [FUNCT3_W-1:0] F3_SW  = 3'b010;

    // One beat as handed to the memory stage
    typedef struct packed {
        logic [XLEN-1:0]     result;
        logic [XLEN-1:0]     store_data;
        logic [REG_W-1:0]    rd;
        logic                reg_write;
        logic                mem_read;
        logic                mem_write;
        logic [FUNCT3_W-1:0] funct3;
        logic                misaligned;
    } mem_beat_t;

    localparam int BEAT_W = $bits(mem_beat_t);

    // Control-flow class of an EX instruction
    typedef enum logic [1:0] {
        CF_NONE   = 2'd0,
        CF_PC_REL = 2'd1,   // taken branch or JAL: pc + imm
        CF_REG    = 2'd2    // JALR: alu_out with bit 0 cleared
    } cf_kind_e;

    // Redirect target for a given control-flow class; adds wrap mod 2^XLEN
    function automatic logic [XLEN-1:0] cf_target(input cf_kind_e kind,
                                                  input logic [XLEN-1:0] pc,
                                                  input logic [XLEN-1:0] imm,
                                                  input logic [XLEN-1:0] alu_out);
        logic [XLEN-1:0] tgt;
        tgt = pc + imm;
        if (kind == CF_REG) tgt = {alu_out[XLEN-1:1], 1'b0};
        return tgt;
    endfunction

endpackage

// File: rtl/pipe_skid_buf.sv
// Generic 2-entry valid/ready skid buffer. in_ready is a flop (!skid full),
// so no combinational path runs from out_ready back to the producer.
module pipe_skid_buf #(
    parameter int WIDTH = 8
) (
    input  logic             clk,
    input  logic             rst_n,
    input  logic             in_valid,
    output logic             in_ready,
    input  logic [WIDTH-1:0] in_data,
    output logic             out_valid,
    input  logic             out_ready,
    output logic [WIDTH-1:0] out_data
);

    logic             main_valid;
    logic [WIDTH-1:0] main_data;
    logic             skid_valid;
    logic [WIDTH-1:0] skid_data;
    logic             push;

    assign in_ready  = !skid_valid;
    assign push      = in_valid && in_ready;
    assign out_valid = main_valid;
    assign out_data  = main_data;

    // Main register refills from skid (oldest first) or from input whenever it is empty or draining
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            // NOTE: data registers are reset too, so the outputs read all-zero out of reset.
            main_valid <= 1'b0;
            main_data  <= '0;
            skid_valid <= 1'b0;
            skid_data  <= '0;
        end else if (!main_valid || out_ready) begin
            // NOTE: non-blocking assignments let every flop sample the pre-edge state.
            if (skid_valid) begin
                main_valid <= 1'b1;
                main_data  <= skid_data;
                skid_valid <= push;
                if (push) skid_data <= in_data;
            end else begin
                main_valid <= push;
                if (push) main_data <= in_data;
            end
        end else if (push) begin
            skid_valid <= 1'b1;
            skid_data  <= in_data;
        end
    end

endmodule

// File: rtl/ex_mem_stage.sv
// EX->MEM pipeline stage: packs the ALU result and sideband into a beat,
// resolves branches/jumps into a one-cycle redirect and drops wrong-path beats.
module ex_mem_stage
    import ex_mem_stage_pkg::*;
#(
    parameter int XLEN         = 32,
    parameter int FLUSH_SHADOW = 1
) (
    input  logic            clk,
    input  logic            rst_n,
    input  logic            in_valid,
    output logic            in_ready,
    input  logic [XLEN-1:0] in_pc,
    input  logic [XLEN-1:0] in_imm,
    input  logic [XLEN-1:0] in_alu_out,
    input  logic            in_branch_enable,
    input  logic            in_is_branch,
    input  logic            in_is_jal,
    input  logic            in_is_jalr,
    input  logic [4:0]      in_rd,
    input  logic            in_reg_write,
    input  logic            in_mem_read,
    input  logic            in_mem_write,
    input  logic [XLEN-1:0] in_store_data,
    input  logic [2:0]      in_funct3,
    output logic            out_valid,
    input  logic            out_ready,
    output logic [XLEN-1:0] out_result,
    output logic [XLEN-1:0] out_store_data,
    output logic [4:0]      out_rd,
    output logic            out_reg_write,
    output logic            out_mem_read,
    output logic            out_mem_write,
    output logic [2:0]      out_funct3,
    output logic            out_misaligned,
    output logic            redirect_valid,
    output logic [XLEN-1:0] redirect_pc
);

    localparam int SHADOW_W = (FLUSH_SHADOW > 0) ? $clog2(FLUSH_SHADOW + 1) : 1;
    localparam logic [SHADOW_W-1:0] SHADOW_LOAD = SHADOW_W'(FLUSH_SHADOW);

    cf_kind_e            cf_kind;
    logic                take;
    logic [XLEN-1:0]     target;
    logic                accept;
    logic                kill;
    logic                push;
    logic [SHADOW_W-1:0] shadow_cnt;
    mem_beat_t           in_beat;
    mem_beat_t           out_beat;

    // Classify the incoming instruction and build the beat for the memory stage
    always_comb begin
        // NOTE: every combinational output gets a default first so no latch is inferred.
        cf_kind = CF_NONE;
        if (in_is_jalr)                                       cf_kind = CF_REG;
        else if (in_is_jal || (in_is_branch && in_branch_enable)) cf_kind = CF_PC_REL;

        take   = (cf_kind != CF_NONE);
        target = cf_target(cf_kind, in_pc, in_imm, in_alu_out);

        in_beat            = '0;
        in_beat.result     = (in_is_jal || in_is_jalr) ? in_pc + XLEN'(4) : in_alu_out;
        in_beat.store_data = in_store_data;
        in_beat.rd         = in_rd;
        // Branches never write back or touch memory, taken or not
        in_beat.reg_write  = in_reg_write && !in_is_branch;
        in_beat.mem_read   = in_mem_read  && !in_is_branch;
        in_beat.mem_write  = in_mem_write && !in_is_branch;
        in_beat.funct3     = in_funct3;
        in_beat.misaligned = take && target[1];
    end

    assign accept = in_valid && in_ready;
    assign kill   = accept && (shadow_cnt != '0);
    assign push   = accept && !kill;

    pipe_skid_buf #(
        .WIDTH(BEAT_W)
    ) u_skid (
        .clk      (clk),
        .rst_n    (rst_n),
        .in_valid (push),
        .in_ready (in_ready),
        .in_data  (in_beat),
        .out_valid(out_valid),
        .out_ready(out_ready),
        .out_data (out_beat)
    );

    assign out_result     = out_beat.result;
    assign out_store_data = out_beat.store_data;
    assign out_rd         = out_beat.rd;
    assign out_reg_write  = out_beat.reg_write;
    assign out_mem_read   = out_beat.mem_read;
    assign out_mem_write  = out_beat.mem_write;
    assign out_funct3     = out_beat.funct3;
    assign out_misaligned = out_beat.misaligned;

    // Register the redirect pulse and count down the wrong-path shadow on each accepted beat
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            redirect_valid <= 1'b0;
            redirect_pc    <= '0;
            shadow_cnt     <= '0;
        end else begin
            redirect_valid <= push && take;
            if (push && take) redirect_pc <= target;
            if (kill)               shadow_cnt <= shadow_cnt - SHADOW_W'(1);
            else if (push && take)  shadow_cnt <= SHADOW_LOAD;
        end
    end

endmodule

// File: tb/tb_ex_mem_stage.sv
// Self-checking bench for ex_mem_stage: directed vector table, hand sequences
// for reset/stall/shadow corners, and a randomized stream against a queue model.
module tb_ex_mem_stage;

    localparam int FLUSH_SHADOW = 1;

    logic        clk = 1'b0;
    logic        rst_n = 1'b0;
    logic        in_valid, in_ready;
    logic [31:0] in_pc, in_imm, in_alu_out, in_store_data;
    logic        in_branch_enable, in_is_branch, in_is_jal, in_is_jalr;
    logic [4:0]  in_rd;
    logic        in_reg_write, in_mem_read, in_mem_write;
    logic [2:0]  in_funct3;
    logic        out_valid, out_ready;
    logic [31:0] out_result, out_store_data;
    logic [4:0]  out_rd;
    logic        out_reg_write, out_mem_read, out_mem_write;
    logic [2:0]  out_funct3;
    logic        out_misaligned;
    logic        redirect_valid;
    logic [31:0] redirect_pc;

    always #5 clk = ~clk;

    ex_mem_stage #(.XLEN(32), .FLUSH_SHADOW(FLUSH_SHADOW)) dut (
        .clk(clk), .rst_n(rst_n),
        .in_valid(in_valid), .in_ready(in_ready),
        .in_pc(in_pc), .in_imm(in_imm), .in_alu_out(in_alu_out),
        .in_branch_enable(in_branch_enable), .in_is_branch(in_is_branch),
        .in_is_jal(in_is_jal), .in_is_jalr(in_is_jalr),
        .in_rd(in_rd), .in_reg_write(in_reg_write),
        .in_mem_read(in_mem_read), .in_mem_write(in_mem_write),
        .in_store_data(in_store_data), .in_funct3(in_funct3),
        .out_valid(out_valid), .out_ready(out_ready),
        .out_result(out_result), .out_store_data(out_store_data),
        .out_rd(out_rd), .out_reg_write(out_reg_write),
        .out_mem_read(out_mem_read), .out_mem_write(out_mem_write),
        .out_funct3(out_funct3), .out_misaligned(out_misaligned),
        .redirect_valid(redirect_valid), .redirect_pc(redirect_pc)
    );

    // Expected memory-stage beat
    typedef struct {
        logic [31:0] result;
        logic [31:0] store_data;
        logic [4:0]  rd;
        logic        rw, mr, mw;
        logic [2:0]  f3;
        logic        mis;
    } exp_t;

    // Directed vector: kind 0=ALU 1=branch 2=JAL 3=JALR
    typedef struct {
        int          kind;
        logic [31:0] pc, imm, alu;
        logic        br_en;
        logic [31:0] exp_result;
        logic        exp_rv;
        logic [31:0] exp_rpc;
        logic        exp_mis;
        logic        exp_rw;
    } vec_t;

    exp_t        q[$];
    bit          exp_rv;
    logic [31:0] exp_rpc;
    int          shadow;
    int          checks = 0;
    int          failures = 0;

    task automatic check(input string name, input logic [75:0] act, input logic [75:0] exp);
        checks++;
        if (act !== exp) begin
            failures++;
            $display("FAIL %s: got %h expected %h", name, act, exp);
        end
    endtask

    function automatic logic [75:0] pack_exp(input exp_t e);
        return {e.result, e.store_data, e.rd, e.rw, e.mr, e.mw, e.f3, e.mis};
    endfunction

    task automatic set_beat(input int kind, input logic [31:0] pc, input logic [31:0] imm,
                            input logic [31:0] alu, input logic br_en);
        in_valid         = 1'b1;
        in_pc            = pc;
        in_imm           = imm;
        in_alu_out       = alu;
        in_branch_enable = br_en;
        in_is_branch     = (kind == 1);
        in_is_jal        = (kind == 2);
        in_is_jalr       = (kind == 3);
        in_rd            = 5'd3;
        in_reg_write     = 1'b1;
        in_mem_read      = 1'b0;
        in_mem_write     = 1'b0;
        in_store_data    = 32'hDEAD_BEEF;
        in_funct3        = 3'b010;
    endtask

    // Compare registered outputs against the model, then advance the model by one clock.
    // Called just after a falling edge with the inputs for this cycle already applied.
    task automatic step(output bit acc);
        exp_t        e;
        bit          take;
        logic [31:0] tgt;
        check("in_ready", in_ready, q.size() < 2);
        check("out_valid", out_valid, q.size() > 0);
        if (q.size() > 0)
            check("out_beat", {out_result, out_store_data, out_rd, out_reg_write, out_mem_read,
                               out_mem_write, out_funct3, out_misaligned}, pack_exp(q[0]));
        check("redirect_valid", redirect_valid, exp_rv);
        if (exp_rv) check("redirect_pc", redirect_pc, exp_rpc);

        acc = in_valid && (q.size() < 2);
        if (q.size() > 0 && out_ready) void'(q.pop_front());
        exp_rv = 1'b0;
        take = in_is_jal || in_is_jalr || (in_is_branch && in_branch_enable);
        tgt  = in_is_jalr ? {in_alu_out[31:1], 1'b0} : in_pc + in_imm;
        if (acc) begin
            if (shadow > 0) begin
                shadow--;
            end else begin
                e.result     = (in_is_jal || in_is_jalr) ? in_pc + 32'd4 : in_alu_out;
                e.store_data = in_store_data;
                e.rd         = in_rd;
                e.rw         = in_is_branch ? 1'b0 : in_reg_write;
                e.mr         = in_is_branch ? 1'b0 : in_mem_read;
                e.mw         = in_is_branch ? 1'b0 : in_mem_write;
                e.f3         = in_funct3;
                e.mis        = take ? tgt[1] : 1'b0;
                q.push_back(e);
                if (take) begin
                    exp_rv  = 1'b1;
                    exp_rpc = tgt;
                    shadow  = FLUSH_SHADOW;
                end
            end
        end
        @(posedge clk);
        @(negedge clk);
    endtask

    vec_t vecs[7];
    bit   acc;

    initial begin
        vecs[0] = '{0, 32'h0000_0010, 32'h0,         32'h0000_1234, 1'b0, 32'h0000_1234, 1'b0, 32'h0,         1'b0, 1'b1};
        vecs[1] = '{1, 32'h0000_0100, 32'h40,        32'h0000_0001, 1'b1, 32'h0000_0001, 1'b1, 32'h0000_0140, 1'b0, 1'b0};
        vecs[2] = '{1, 32'h0000_0200, 32'h40,        32'h0000_0000, 1'b0, 32'h0000_0000, 1'b0, 32'h0,         1'b0, 1'b0};
        vecs[3] = '{3, 32'h0000_0080, 32'h0,         32'h0000_2003, 1'b0, 32'h0000_0084, 1'b1, 32'h0000_2002, 1'b1, 1'b1};
        vecs[4] = '{2, 32'hFFFF_FFFC, 32'h8,         32'h0,         1'b0, 32'h0000_0000, 1'b1, 32'h0000_0004, 1'b0, 1'b1};
        vecs[5] = '{1, 32'h0000_0100, 32'h42,        32'h0000_0001, 1'b1, 32'h0000_0001, 1'b1, 32'h0000_0142, 1'b1, 1'b0};
        vecs[6] = '{2, 32'h0000_1000, 32'hFFFF_FFF0, 32'h0,         1'b0, 32'h0000_1004, 1'b1, 32'h0000_0FF0, 1'b0, 1'b1};

        set_beat(0, 32'h0, 32'h0, 32'h0, 1'b0);
        in_valid  = 1'b0;
        out_ready = 1'b1;
        exp_rv    = 1'b0;
        exp_rpc   = '0;
        shadow    = 0;
        repeat (2) @(negedge clk);
        check("reset_out_valid", out_valid, 1'b0);
        check("reset_redirect_valid", redirect_valid, 1'b0);
        check("reset_out_result", out_result, 32'h0);
        check("reset_redirect_pc", redirect_pc, 32'h0);
        rst_n = 1'b1;
        @(negedge clk);
        check("reset_in_ready", in_ready, 1'b1);

        // Directed vector table, one beat at a time with MEM always ready
        for (int i = 0; i < 7; i++) begin
            set_beat(vecs[i].kind, vecs[i].pc, vecs[i].imm, vecs[i].alu, vecs[i].br_en);
            step(acc);
            in_valid = 1'b0;
            check($sformatf("vec%0d_out_valid", i), out_valid, 1'b1);
            check($sformatf("vec%0d_result", i), out_result, vecs[i].exp_result);
            check($sformatf("vec%0d_misaligned", i), out_misaligned, vecs[i].exp_mis);
            check($sformatf("vec%0d_reg_write", i), out_reg_write, vecs[i].exp_rw);
            check($sformatf("vec%0d_redirect_valid", i), redirect_valid, vecs[i].exp_rv);
            if (vecs[i].exp_rv) begin
                check($sformatf("vec%0d_redirect_pc", i), redirect_pc, vecs[i].exp_rpc);
                set_beat(0, 32'h0000_0500, 32'h0, 32'h0000_BAD0, 1'b0);
                step(acc);
                in_valid = 1'b0;
                check($sformatf("vec%0d_shadow_drop", i), out_valid, 1'b0);
            end
            step(acc);
        end

        // Stream 4 ADD beats back to back: one per cycle, no bubbles
        for (int i = 0; i < 4; i++) begin
            set_beat(0, 32'h100 + 32'(i * 4), 32'h0, 32'hA000 + 32'(i), 1'b0);
            step(acc);
            check("stream_accept", acc, 1'b1);
        end
        in_valid = 1'b0;
        step(acc);
        step(acc);

        // Stall MEM for 3 cycles while feeding; in_ready drops after two accepts
        out_ready = 1'b0;
        for (int i = 0; i < 3; i++) begin
            set_beat(0, 32'h200, 32'h0, 32'hB000 + 32'(i), 1'b0);
            step(acc);
            check("stall_accept", acc, i < 2);
        end
        check("stall_in_ready_low", in_ready, 1'b0);
        out_ready = 1'b1;
        for (int n = 0; n < 10 && !acc; n++) step(acc);
        check("stall_third_accepted", acc, 1'b1);
        in_valid = 1'b0;
        repeat (3) step(acc);

        // Shadow only counts accepted beats: idle cycles after a JAL do not clear it
        set_beat(2, 32'h300, 32'h20, 32'h0, 1'b0);
        step(acc);
        in_valid = 1'b0;
        step(acc);
        step(acc);
        set_beat(0, 32'h304, 32'h0, 32'hC001, 1'b0);
        step(acc);
        set_beat(0, 32'h320, 32'h0, 32'hC002, 1'b0);
        step(acc);
        in_valid = 1'b0;
        check("shadow_survivor", out_result, 32'hC002);
        step(acc);

        // Asynchronous reset with two beats held and a redirect pulse pending
        out_ready = 1'b0;
        set_beat(0, 32'h400, 32'h0, 32'hD000, 1'b0);
        step(acc);
        set_beat(2, 32'h404, 32'h10, 32'h0, 1'b0);
        step(acc);
        in_valid = 1'b0;
        check("prereset_held_full", in_ready, 1'b0);
        check("prereset_redirect", redirect_valid, 1'b1);
        #1 rst_n = 1'b0;
        #1;
        check("async_reset_out_valid", out_valid, 1'b0);
        check("async_reset_redirect_valid", redirect_valid, 1'b0);
        q.delete();
        exp_rv = 1'b0;
        shadow = 0;
        #1 rst_n = 1'b1;
        #1;
        check("release_in_ready", in_ready, 1'b1);
        @(negedge clk);
        out_ready = 1'b1;
        set_beat(0, 32'h500, 32'h0, 32'hE000, 1'b0);
        step(acc);
        in_valid = 1'b0;
        step(acc);

        // Randomized stream against the queue model
        for (int c = 0; c < 600; c++) begin
            int k;
            k = $urandom_range(0, 9);
            set_beat((k < 6) ? 0 : (k < 8) ? 1 : (k < 9) ? 2 : 3,
                     $urandom, $urandom, $urandom, 1'($urandom_range(0, 1)));
            in_valid      = ($urandom_range(0, 3) != 0);
            in_rd         = 5'($urandom);
            in_reg_write  = 1'($urandom);
            in_mem_read   = in_is_branch ? 1'b0 : 1'($urandom);
            in_mem_write  = in_is_branch ? 1'b0 : 1'($urandom);
            in_store_data = $urandom;
            in_funct3     = 3'($urandom);
            out_ready     = ($urandom_range(0, 9) < 7);
            step(acc);
        end
        in_valid  = 1'b0;
        out_ready = 1'b1;
        repeat (4) step(acc);
        check("final_drained", out_valid, 1'b0);

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule
